// File: rtl/uart_key_pkg.sv
// Shared constants, FSM encoding and echo formatting for the UART key decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_key_pkg;

    // ASCII codes of the default key set
    localparam logic [7:0] ASCII_W       = 8'h77;
    localparam logic [7:0] ASCII_S       = 8'h73;
    localparam logic [7:0] ASCII_A       = 8'h61;
    localparam logic [7:0] ASCII_D       = 8'h64;
    localparam logic [7:0] ASCII_J       = 8'h6A;
    localparam logic [7:0] ASCII_K       = 8'h6B;
    localparam logic [7:0] ASCII_L       = 8'h6C;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;

    // Lowercase range and the offset that folds it to uppercase
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;

    // Key i occupies bits [8i+7:8i]; the first listed code is the highest index
    localparam logic [63:0] DEFAULT_KEY_CODES = {ASCII_W, ASCII_S, ASCII_A, ASCII_D,
                                                 ASCII_J, ASCII_K, ASCII_L, ASCII_SPACE};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_ECHO = 2'd2
    } state_t;

    // Lowercase letters echo as uppercase, anything else echoes as the alternate byte
    function automatic logic [7:0] echo_byte(input logic [7:0] code, input logic [7:0] alt);
        if (code >= ASCII_LOWER_A && code <= ASCII_LOWER_Z) begin
            return code - CASE_OFFSET;
        end
        return alt;
    endfunction

endpackage

// File: rtl/uart_key_decoder_if.sv
// Byte-level handshake between the key decoder and the RX/TX FIFOs of uart_fifo.
// Latency: n/a (wiring only).
// Backpressure: rx_fifo_empty stalls popping, tx_fifo_full stalls the echo write.
interface uart_key_decoder_if;
    logic [7:0] rx_byte;
    logic       rx_fifo_empty;
    logic       rx_fifo_pop;
    logic       tx_fifo_full;
    logic [7:0] tx_byte;
    logic       transmit;

    // Decoder side: consumes RX bytes and produces TX writes
    modport master (
        input  rx_byte,
        input  rx_fifo_empty,
        input  tx_fifo_full,
        output rx_fifo_pop,
        output tx_byte,
        output transmit
    );

    // FIFO side
    modport slave (
        output rx_byte,
        output rx_fifo_empty,
        output tx_fifo_full,
        input  rx_fifo_pop,
        input  tx_byte,
        input  transmit
    );
endinterface

// File: rtl/key_hold_timer.sv
// Per-key hold timer: held stays high HOLD_CYCLES cycles after the last load; HOLD_CYCLES=0 latches.
// Latency: held rises the cycle after load, falls the cycle after clear.
// Backpressure: none; load and clear are accepted every cycle.
module key_hold_timer #(
    parameter int HOLD_CYCLES = 5_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic load,
    input  logic clear,
    output logic held
);

    generate
        if (HOLD_CYCLES == 0) begin : g_latch
            logic latched;

            // Latch mode: set on load, cleared only by reset or an explicit clear
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    latched <= 1'b0;
                end else if (clear) begin
                    latched <= 1'b0;
                end else if (load) begin
                    latched <= 1'b1;
                end
            end

            assign held = latched;
        end else begin : g_count
            localparam int CW = $clog2(HOLD_CYCLES + 1);
            localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);

            logic [CW-1:0] cnt;

            // Reload beats decrement, so a press landing on cnt==1 never lets the key drop
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (load) begin
                    cnt <= HOLD_VAL;
                end else if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end

            assign held = (cnt != '0);
        end
    endgenerate

endmodule

// File: rtl/uart_key_decoder.sv
// Pops RX bytes, matches them against a key table, drives held/press outputs and echoes hits.
// Latency: pop 1 cycle after !empty, key_press/keys 1 cycle later, transmit 1 cycle after that.
// Backpressure: no pop while busy; echo waits in ECHO while tx_fifo_full, blocking new bytes.
module uart_key_decoder
    import uart_key_pkg::*;
#(
    parameter int                      NUM_KEYS    = 8,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES   = DEFAULT_KEY_CODES,
    parameter int                      HOLD_CYCLES = 5_000_000,
    parameter bit                      ECHO_EN     = 1'b1,
    parameter logic [7:0]              ECHO_ALT    = 8'h5A,
    parameter bit                      CLR_ON_UNK  = 1'b1
) (
    input  logic                CLK,
    input  logic                RESET,
    uart_key_decoder_if.master  fifo,
    output logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [7:0]          unk_count
);

    state_t              state;
    logic [7:0]          byte_q;
    logic                pop_q;
    logic                transmit_q;
    logic [7:0]          tx_byte_q;
    logic                hit;
    logic [NUM_KEYS-1:0] hit_vec;
    logic [NUM_KEYS-1:0] load_vec;
    logic                clear_all;

    assign fifo.rx_fifo_pop = pop_q;
    assign fifo.transmit    = transmit_q;
    assign fifo.tx_byte     = tx_byte_q;

    // Priority match: scanning high to low lets the lowest matching index win
    always_comb begin
        hit     = 1'b0;
        hit_vec = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (byte_q == KEY_CODES[8*i +: 8]) begin
                hit        = 1'b1;
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
            end
        end
    end

    // Timer controls act on the same edge the FSM leaves POP
    always_comb begin
        load_vec  = (state == ST_POP) ? hit_vec : '0;
        clear_all = (state == ST_POP) && !hit && CLR_ON_UNK;
    end

    // Decode FSM with registered pop, press, echo and unknown-byte count
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            byte_q     <= '0;
            pop_q      <= 1'b0;
            transmit_q <= 1'b0;
            tx_byte_q  <= '0;
            key_press  <= '0;
            unk_count  <= '0;
        end else begin
            pop_q      <= 1'b0;
            transmit_q <= 1'b0;
            key_press  <= '0;
            case (state)
                ST_IDLE: begin
                    if (!fifo.rx_fifo_empty) begin
                        byte_q <= fifo.rx_byte;
                        pop_q  <= 1'b1;
                        state  <= ST_POP;
                    end
                end
                ST_POP: begin
                    if (hit) begin
                        key_press <= hit_vec;
                        state     <= ECHO_EN ? ST_ECHO : ST_IDLE;
                    end else begin
                        if (unk_count != 8'hFF) begin
                            unk_count <= unk_count + 8'd1;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_ECHO: begin
                    if (!fifo.tx_fifo_full) begin
                        transmit_q <= 1'b1;
                        tx_byte_q  <= echo_byte(byte_q, ECHO_ALT);
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
            key_hold_timer #(
                .HOLD_CYCLES (HOLD_CYCLES)
            ) u_timer (
                .CLK   (CLK),
                .RESET (RESET),
                .load  (load_vec[g]),
                .clear (clear_all),
                .held  (keys[g])
            );
        end
    endgenerate

endmodule
